// File: rtl/fetch_stage.sv
// fetch_stage: instruction-fetch front end.
// Owns the fetch PC and issues word fetches over a req/ack handshake that
// tolerates wait states. Returned instructions are buffered with their PCs
// in a DEPTH-entry prefetch FIFO. A redirect flushes the FIFO and restarts
// fetching at the new target.
// Optional build macro FETCH_PERF_EN enables the fetch and stall performance
// counters. When it is undefined, both perf outputs are tied to zero.
module fetch_stage #(
    parameter int unsigned        DWIDTH   = 32,
    parameter int unsigned        DEPTH    = 4,
    parameter logic [DWIDTH-1:0]  RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              redirect_valid,
    input  logic [DWIDTH-1:0] redirect_pc,
    output logic              mem_req,
    output logic [DWIDTH-1:0] mem_addr,
    input  logic              mem_ack,
    input  logic [DWIDTH-1:0] mem_rdata,
    output logic              inst_valid,
    output logic [DWIDTH-1:0] inst_data,
    output logic [DWIDTH-1:0] inst_pc,
    input  logic              inst_ready,
    output logic [31:0]       perf_fetched,
    output logic [31:0]       perf_stall
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W:0] FULL_COUNT = (PTR_W + 1)'(DEPTH);

    // Clears the byte-offset bits so every fetch is word aligned.
    function automatic logic [DWIDTH-1:0] alignPc(input logic [DWIDTH-1:0] pc);
        return pc & ~DWIDTH'(3);
    endfunction

    // Sequential word address; wraps modulo 2^DWIDTH.
    function automatic logic [DWIDTH-1:0] nextPc(input logic [DWIDTH-1:0] pc);
        return pc + DWIDTH'(4);
    endfunction

    // FIFO pointer advance; DEPTH is a power of two so wrap is natural.
    function automatic logic [PTR_W-1:0] bumpPtr(input logic [PTR_W-1:0] ptr);
        return ptr + PTR_W'(1);
    endfunction

    logic [DWIDTH-1:0] fetchPc;
    logic [PTR_W-1:0]  rdPtr;
    logic [PTR_W-1:0]  wrPtr;
    logic [PTR_W:0]    count;

    logic [DWIDTH-1:0] pcBuf    [DEPTH];
    logic [DWIDTH-1:0] instrBuf [DEPTH];

    logic memReqInt;
    logic pushEn;
    logic popEn;

    // Request only while there is room. Requests are also withheld during reset
    // and redirect, so an ack in a flush cycle can never push stale data.
    assign memReqInt  = !reset && !redirect_valid && (count < FULL_COUNT);
    assign pushEn     = memReqInt && mem_ack;
    assign inst_valid = (count != '0);
    assign popEn      = inst_valid && inst_ready;

    assign mem_req   = memReqInt;
    assign mem_addr  = fetchPc;
    assign inst_data = instrBuf[rdPtr];
    assign inst_pc   = pcBuf[rdPtr];

    // Control state: reset beats redirect, and redirect beats push/pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetchPc <= RESET_PC;
            rdPtr   <= '0;
            wrPtr   <= '0;
            count   <= '0;
        end else if (redirect_valid) begin
            fetchPc <= alignPc(redirect_pc);
            rdPtr   <= '0;
            wrPtr   <= '0;
            count   <= '0;
        end else begin
            if (pushEn) begin
                fetchPc <= nextPc(fetchPc);
                wrPtr   <= bumpPtr(wrPtr);
            end
            if (popEn) begin
                rdPtr <= bumpPtr(rdPtr);
            end
            if (pushEn && !popEn) begin
                count <= count + (PTR_W + 1)'(1);
            end else if (popEn && !pushEn) begin
                count <= count - (PTR_W + 1)'(1);
            end
        end
    end

    // FIFO payload: written on accepted fetches only, never reset.
    always_ff @(posedge clk) begin
        if (pushEn) begin
            pcBuf[wrPtr]    <= fetchPc;
            instrBuf[wrPtr] <= mem_rdata;
        end
    end

`ifdef FETCH_PERF_EN
    logic [31:0] fetchedCnt;
    logic [31:0] stallCnt;

    // Perf counters: cleared only by reset, so they survive redirects.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetchedCnt <= '0;
            stallCnt   <= '0;
        end else begin
            if (pushEn) begin
                fetchedCnt <= fetchedCnt + 32'd1;
            end
            if (memReqInt && !mem_ack) begin
                stallCnt <= stallCnt + 32'd1;
            end
        end
    end

    assign perf_fetched = fetchedCnt;
    assign perf_stall   = stallCnt;
`else
    assign perf_fetched = '0;
    assign perf_stall   = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage (DWIDTH=32, DEPTH=4, RESET_PC=0).
// Inputs change one time unit after each rising edge. Outputs are sampled one
// time unit after that, well clear of the next edge.
module tb_fetch_stage;

`ifdef FETCH_PERF_EN
    localparam bit PerfEn = 1'b1;
`else
    localparam bit PerfEn = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        inst_valid;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        inst_ready;
    logic [31:0] perf_fetched;
    logic [31:0] perf_stall;

    int vectors;
    int miscompares;

    fetch_stage #(
        .DWIDTH  (32),
        .DEPTH   (4),
        .RESET_PC(32'h0000_0000)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc),
        .mem_req       (mem_req),
        .mem_addr      (mem_addr),
        .mem_ack       (mem_ack),
        .mem_rdata     (mem_rdata),
        .inst_valid    (inst_valid),
        .inst_data     (inst_data),
        .inst_pc       (inst_pc),
        .inst_ready    (inst_ready),
        .perf_fetched  (perf_fetched),
        .perf_stall    (perf_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Instruction memory model: contents are a fixed function of the address.
    function automatic logic [31:0] memWord(input logic [31:0] a);
        return {~a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    assign mem_rdata = memWord(mem_addr);

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench in the first non-reset cycle with all inputs idle.
    task automatic doReset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        mem_ack        = 1'b0;
        inst_ready     = 1'b0;
        nextCycle();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        mem_ack        = 1'b1;
        inst_ready     = 1'b1;
        nextCycle();
        nextCycle();
        #1;
        vectors++;
        if (mem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mem_req: got %b want 0", mem_req);
        end
        vectors++;
        if (inst_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_inst_valid: got %b want 0", inst_valid);
        end
        vectors++;
        if (mem_addr !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_mem_addr: got %h want 00000000", mem_addr);
        end
        vectors++;
        if (perf_fetched !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_perf_fetched: got %0d want 0", perf_fetched);
        end
        vectors++;
        if (perf_stall !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_perf_stall: got %0d want 0", perf_stall);
        end
    endtask

    task automatic test_stream();
        logic [31:0] expF;
        doReset();
        mem_ack    = 1'b1;
        inst_ready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i > 0) nextCycle();
            #1;
            vectors++;
            if (mem_req !== 1'b1 || mem_addr !== 32'(4 * i)) begin
                miscompares++;
                $display("FAIL stream_req cyc%0d: got req=%b addr=%h want req=1 addr=%h",
                         i, mem_req, mem_addr, 32'(4 * i));
            end
            vectors++;
            if (inst_valid !== (i > 0)) begin
                miscompares++;
                $display("FAIL stream_valid cyc%0d: got %b want %b", i, inst_valid, (i > 0));
            end
            if (i > 0) begin
                vectors++;
                if (inst_pc !== 32'(4 * (i - 1)) || inst_data !== memWord(32'(4 * (i - 1)))) begin
                    miscompares++;
                    $display("FAIL stream_inst cyc%0d: got pc=%h data=%h want pc=%h data=%h",
                             i, inst_pc, inst_data, 32'(4 * (i - 1)), memWord(32'(4 * (i - 1))));
                end
            end
        end
        nextCycle();
        #1;
        expF = PerfEn ? 32'd6 : 32'd0;
        vectors++;
        if (perf_fetched !== expF || perf_stall !== 32'd0) begin
            miscompares++;
            $display("FAIL stream_perf: got fetched=%0d stall=%0d want fetched=%0d stall=0",
                     perf_fetched, perf_stall, expF);
        end
    endtask

    task automatic test_fill();
        doReset();
        mem_ack    = 1'b1;
        inst_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > 0) nextCycle();
            #1;
            vectors++;
            if (mem_req !== 1'b1 || mem_addr !== 32'(4 * i)) begin
                miscompares++;
                $display("FAIL fill_req cyc%0d: got req=%b addr=%h want req=1 addr=%h",
                         i, mem_req, mem_addr, 32'(4 * i));
            end
        end
        nextCycle();
        #1;
        vectors++;
        if (mem_req !== 1'b0 || mem_addr !== 32'h10 || inst_valid !== 1'b1 || inst_pc !== 32'h0) begin
            miscompares++;
            $display("FAIL fill_full: got req=%b addr=%h valid=%b pc=%h want req=0 addr=10 valid=1 pc=0",
                     mem_req, mem_addr, inst_valid, inst_pc);
        end
        nextCycle();
        inst_ready = 1'b1;
        #1;
        vectors++;
        if (mem_req !== 1'b0 || mem_addr !== 32'h10) begin
            miscompares++;
            $display("FAIL fill_hold: got req=%b addr=%h want req=0 addr=10", mem_req, mem_addr);
        end
        for (int k = 0; k < 5; k++) begin
            if (k > 0) nextCycle();
            #1;
            vectors++;
            if (inst_valid !== 1'b1 || inst_pc !== 32'(4 * k) || inst_data !== memWord(32'(4 * k))) begin
                miscompares++;
                $display("FAIL fill_pop k%0d: got valid=%b pc=%h data=%h want valid=1 pc=%h data=%h",
                         k, inst_valid, inst_pc, inst_data, 32'(4 * k), memWord(32'(4 * k)));
            end
            if (k == 1) begin
                vectors++;
                if (mem_req !== 1'b1 || mem_addr !== 32'h10) begin
                    miscompares++;
                    $display("FAIL fill_rereq: got req=%b addr=%h want req=1 addr=10", mem_req, mem_addr);
                end
            end
        end
    endtask

    task automatic test_wait();
        logic [31:0] expP;
        doReset();
        mem_ack    = 1'b1;
        inst_ready = 1'b1;
        #1;
        nextCycle();
        #1;
        vectors++;
        if (mem_addr !== 32'h4 || inst_pc !== 32'h0 || inst_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL wait_pre: got addr=%h valid=%b pc=%h want addr=4 valid=1 pc=0",
                     mem_addr, inst_valid, inst_pc);
        end
        nextCycle();
        mem_ack = 1'b0;
        for (int j = 0; j < 3; j++) begin
            if (j > 0) nextCycle();
            #1;
            vectors++;
            if (mem_req !== 1'b1 || mem_addr !== 32'h8) begin
                miscompares++;
                $display("FAIL wait_stable w%0d: got req=%b addr=%h want req=1 addr=8", j, mem_req, mem_addr);
            end
            vectors++;
            if (inst_valid !== (j == 0)) begin
                miscompares++;
                $display("FAIL wait_valid w%0d: got %b want %b", j, inst_valid, (j == 0));
            end
        end
        nextCycle();
        mem_ack = 1'b1;
        #1;
        vectors++;
        if (mem_req !== 1'b1 || mem_addr !== 32'h8 || inst_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL wait_ack: got req=%b addr=%h valid=%b want req=1 addr=8 valid=0",
                     mem_req, mem_addr, inst_valid);
        end
        nextCycle();
        mem_ack = 1'b0;
        #1;
        vectors++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h8 || mem_addr !== 32'hC) begin
            miscompares++;
            $display("FAIL wait_done: got valid=%b pc=%h addr=%h want valid=1 pc=8 addr=c",
                     inst_valid, inst_pc, mem_addr);
        end
        expP = PerfEn ? 32'd3 : 32'd0;
        vectors++;
        if (perf_stall !== expP || perf_fetched !== expP) begin
            miscompares++;
            $display("FAIL wait_perf: got stall=%0d fetched=%0d want stall=%0d fetched=%0d",
                     perf_stall, perf_fetched, expP, expP);
        end
    endtask

    task automatic test_redirect();
        logic [31:0] expF;
        doReset();
        mem_ack    = 1'b1;
        inst_ready = 1'b0;
        nextCycle();
        nextCycle();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        inst_ready     = 1'b1;
        #1;
        vectors++;
        if (mem_req !== 1'b0 || inst_valid !== 1'b1 || inst_pc !== 32'h0) begin
            miscompares++;
            $display("FAIL redir_cycle: got req=%b valid=%b pc=%h want req=0 valid=1 pc=0",
                     mem_req, inst_valid, inst_pc);
        end
        nextCycle();
        redirect_valid = 1'b0;
        #1;
        vectors++;
        if (inst_valid !== 1'b0 || mem_req !== 1'b1 || mem_addr !== 32'h100) begin
            miscompares++;
            $display("FAIL redir_flush: got valid=%b req=%b addr=%h want valid=0 req=1 addr=100",
                     inst_valid, mem_req, mem_addr);
        end
        nextCycle();
        #1;
        vectors++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h100 || inst_data !== memWord(32'h100) || mem_addr !== 32'h104) begin
            miscompares++;
            $display("FAIL redir_target: got valid=%b pc=%h data=%h addr=%h want valid=1 pc=100 data=%h addr=104",
                     inst_valid, inst_pc, inst_data, mem_addr, memWord(32'h100));
        end
        nextCycle();
        #1;
        vectors++;
        if (inst_pc !== 32'h104 || inst_data !== memWord(32'h104)) begin
            miscompares++;
            $display("FAIL redir_next: got pc=%h data=%h want pc=104 data=%h",
                     inst_pc, inst_data, memWord(32'h104));
        end
        expF = PerfEn ? 32'd4 : 32'd0;
        vectors++;
        if (perf_fetched !== expF || perf_stall !== 32'd0) begin
            miscompares++;
            $display("FAIL redir_perf: got fetched=%0d stall=%0d want fetched=%0d stall=0",
                     perf_fetched, perf_stall, expF);
        end
    endtask

    task automatic test_back_to_back();
        doReset();
        mem_ack    = 1'b1;
        inst_ready = 1'b0;
        nextCycle();
        nextCycle();
        inst_ready = 1'b1;
        for (int k = 2; k < 8; k++) begin
            if (k > 2) nextCycle();
            #1;
            vectors++;
            if (mem_req !== 1'b1 || mem_addr !== 32'(4 * k) || inst_valid !== 1'b1 ||
                inst_pc !== 32'(4 * (k - 2))) begin
                miscompares++;
                $display("FAIL b2b cyc%0d: got req=%b addr=%h valid=%b pc=%h want req=1 addr=%h valid=1 pc=%h",
                         k, mem_req, mem_addr, inst_valid, inst_pc, 32'(4 * k), 32'(4 * (k - 2)));
            end
        end
        nextCycle();
        mem_ack = 1'b0;
        #1;
        vectors++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h18 || inst_data !== memWord(32'h18)) begin
            miscompares++;
            $display("FAIL b2b_drain0: got valid=%b pc=%h want valid=1 pc=18", inst_valid, inst_pc);
        end
        nextCycle();
        #1;
        vectors++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h1C || inst_data !== memWord(32'h1C)) begin
            miscompares++;
            $display("FAIL b2b_drain1: got valid=%b pc=%h want valid=1 pc=1c", inst_valid, inst_pc);
        end
        nextCycle();
        #1;
        vectors++;
        if (inst_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL b2b_empty: got valid=%b want 0", inst_valid);
        end
    endtask

    task automatic test_wrap();
        logic [31:0] expF;
        doReset();
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFF;
        #1;
        vectors++;
        if (mem_req !== 1'b0) begin
            miscompares++;
            $display("FAIL wrap_redir_req: got %b want 0", mem_req);
        end
        nextCycle();
        redirect_valid = 1'b0;
        mem_ack        = 1'b1;
        inst_ready     = 1'b1;
        #1;
        vectors++;
        if (mem_req !== 1'b1 || mem_addr !== 32'hFFFF_FFFC) begin
            miscompares++;
            $display("FAIL wrap_top: got req=%b addr=%h want req=1 addr=fffffffc", mem_req, mem_addr);
        end
        nextCycle();
        #1;
        vectors++;
        if (mem_addr !== 32'h0 || inst_pc !== 32'hFFFF_FFFC || inst_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL wrap_zero: got addr=%h valid=%b pc=%h want addr=0 valid=1 pc=fffffffc",
                     mem_addr, inst_valid, inst_pc);
        end
        nextCycle();
        #1;
        vectors++;
        if (mem_addr !== 32'h4 || inst_pc !== 32'h0) begin
            miscompares++;
            $display("FAIL wrap_after: got addr=%h pc=%h want addr=4 pc=0", mem_addr, inst_pc);
        end
        expF = PerfEn ? 32'd2 : 32'd0;
        vectors++;
        if (perf_fetched !== expF || perf_stall !== 32'd0) begin
            miscompares++;
            $display("FAIL wrap_perf: got fetched=%0d stall=%0d want fetched=%0d stall=0",
                     perf_fetched, perf_stall, expF);
        end
    endtask

    initial begin
        vectors        = 0;
        miscompares    = 0;
        reset          = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        mem_ack        = 1'b0;
        inst_ready     = 1'b0;
        test_reset();
        test_stream();
        test_fill();
        test_wait();
        test_redirect();
        test_back_to_back();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Parametrised instruction-fetch front end that succeeds the PC-plus-instruction-memory arrangement of the single-cycle datapath. It owns the fetch PC, issues word fetches over a req/ack memory handshake that tolerates wait states, and buffers returned instructions in a DEPTH-entry prefetch FIFO. It also handles redirects from branch/jump resolution by flushing the buffer. It sits between instruction memory and the decode/register-file stage of the multi-cycle/pipelined datapath.

## Interface
Parameters:
- DWIDTH, 32, instruction and address width
- DEPTH, 4, prefetch FIFO entries; power of two, ≥2
- RESET_PC, 32'h0000_0000, fetch PC after reset

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high reset
- redirect_valid  input  1  branch/jump taken; flush and refetch
- redirect_pc  input  DWIDTH  new fetch address; bits [1:0] are cleared internally
- mem_req  output  1  fetch request
- mem_addr  output  DWIDTH  word-aligned fetch address
- mem_ack  input  1  request accepted; mem_rdata valid this cycle
- mem_rdata  input  DWIDTH  fetched instruction
- inst_valid  output  1  FIFO head valid
- inst_data  output  DWIDTH  instruction at head
- inst_pc  output  DWIDTH  address of inst_data
- inst_ready  input  1  consumer pops head when inst_valid && inst_ready
- perf_fetched  output  32  accepted fetch count
- perf_stall  output  32  wait-state cycle count

## Operation
- State: fetch_pc, FIFO (DEPTH × {pc, instr}), rd/wr pointers of log2(DEPTH) bits, count of log2(DEPTH)+1 bits.
- mem_req = !reset && !redirect_valid && (count < DEPTH). mem_addr = fetch_pc.
- Fetch accept: mem_req && mem_ack. Push {fetch_pc, mem_rdata}; fetch_pc <= fetch_pc + 4, wrapping modulo 2^DWIDTH.
- Once asserted, mem_req and mem_addr stay stable until ack or redirect. count cannot rise without an ack, so this holds by construction.
- Pop: inst_valid && inst_ready; rd pointer advances.
- Push and pop in the same cycle: count is unchanged and both pointers advance.
- Push when full cannot occur, because mem_req is low at count == DEPTH.
- Pop when empty is ignored, because inst_valid is low.
- Pointers wrap naturally at DEPTH.
- inst_valid = (count != 0). inst_data and inst_pc come from the head entry and are combinational from the registered storage.
- Redirect in cycle N:
  - count and both pointers <= 0; fetch_pc <= {redirect_pc[DWIDTH-1:2], 2'b00}.
  - mem_req is low in cycle N, so any mem_ack in cycle N is ignored and nothing is pushed.
  - A pop in cycle N is permitted: the consumer sees the old head, which is then discarded.
- Redirect has priority over push and pop for all state updates.
- Reset has priority over everything: fetch_pc <= RESET_PC, count/pointers <= 0, perf counters <= 0.

## Timing
- Output values during and after reset: mem_req 0 in the reset cycle; inst_valid 0; mem_addr = RESET_PC; perf_fetched and perf_stall 0. inst_data and inst_pc are don't-care while inst_valid is 0.
- Reset deasserted at cycle R: mem_req = 1 with mem_addr = RESET_PC in cycle R+1 (the first non-reset cycle).
- Zero-wait memory: ack in cycle A gives inst_valid in cycle A+1. Sustained throughput is one instruction per cycle while inst_ready = 1.
- Redirect in cycle N: mem_req with the new address in N+1. With a zero-wait ack in N+1, inst_valid with inst_pc = redirect target in N+2.
- W wait states add W cycles. mem_ack is only meaningful while mem_req is high.

## Configuration
- FETCH_PERF_EN defined:
  - perf_fetched increments on each fetch accept.
  - perf_stall increments on each cycle with mem_req && !mem_ack.
  - Both counters are 32-bit, wrap at 2^32, and clear on reset only (not on redirect).
- FETCH_PERF_EN undefined: perf_fetched and perf_stall are tied to 0 and no counter registers are inferred. The ports remain in both builds.

## Test plan
- Reset release, mem_ack held 1, inst_ready 1:
  - mem_addr sequence 0x0, 0x4, 0x8.
  - inst_pc 0x0 appears the cycle after the first ack.
  - One instruction per cycle thereafter.
- inst_ready 0, mem_ack 1, DEPTH=4:
  - Exactly 4 pushes (PCs 0x0–0xC), then mem_req drops and mem_addr holds 0x10.
  - Raise inst_ready: pop order 0x0, 0x4, 0x8, 0xC; mem_req re-asserts the cycle after the first pop.
- mem_ack delayed 3 cycles on address 0x8: mem_req and mem_addr stay stable for 3 cycles; perf_stall += 3 with FETCH_PERF_EN.
- Redirect to 0x103 while 2 entries are buffered and a request is pending with mem_ack arriving in the same cycle:
  - Next cycle: inst_valid 0 and mem_addr 0x100.
  - The stale ack data is never output.
- FIFO at count 2, push and pop in the same cycle: count stays 2; the pointer wrap past DEPTH-1 yields the correct PC order.
- Fetch PC at 0xFFFF_FFFC acked: next mem_addr = 0x0000_0000. With FETCH_PERF_EN undefined, perf outputs read 0 throughout.
